// File: rtl/motor_pwm_sequencer.sv
// rtl/motor_pwm_sequencer.sv - period-aligned duty sequencer for the motor PWM stage
// Converts RPM commands to duty counts and owns arming and command-loss failsafe.
module motor_pwm_sequencer #(
  parameter int NUM_MOTORS   = 4,
  parameter int DUTY_W       = 7,
  parameter int RPM_MIN      = 500,
  parameter int DUTY_MAX     = 90,
  parameter int ARM_PERIODS  = 16,
  parameter int WDOG_PERIODS = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         arm,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [16*NUM_MOTORS-1:0]     cmd_rpm,
  output logic                         mot_set,
  output logic [DUTY_W*NUM_MOTORS-1:0] mot_duty,
  output logic [1:0]                   state,
  output logic                         fault
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  localparam int ARM_W = $clog2(ARM_PERIODS + 1);
  localparam int WD_W  = $clog2(WDOG_PERIODS + 1);
  localparam int DV_W  = DUTY_W * NUM_MOTORS;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [DV_W-1:0]   shadow_q, shadow_d;
  logic [DV_W-1:0]   duty_q, duty_d;
  logic [DV_W-1:0]   conv_duty;
  logic              set_q, set_d;
  logic              boundary;
  logic              xfer;

  // Subtraction only happens above RPM_MIN, so it never wraps.
  function automatic logic [DUTY_W-1:0] rpm_to_duty(input logic [15:0] rpm);
    logic [15:0] excess;
    excess = 16'd0;
    if (rpm > 16'(RPM_MIN)) begin
      excess = (rpm - 16'(RPM_MIN)) >> 6;
    end
    if (excess > 16'(DUTY_MAX)) begin
      excess = 16'(DUTY_MAX);
    end
    return excess[DUTY_W-1:0];
  endfunction

  always_comb begin
    conv_duty = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      conv_duty[i*DUTY_W +: DUTY_W] = rpm_to_duty(cmd_rpm[i*16 +: 16]);
    end
  end

  assign boundary  = (cnt_q == {DUTY_W{1'b1}});
  assign cmd_ready = (state_q == ST_ARMING) || (state_q == ST_RUN);
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DUTY_W'(1);
    arm_cnt_d = arm_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    shadow_d  = shadow_q;
    duty_d    = duty_q;
    set_d     = boundary;

    // Duty loads from the pre-edge shadow, so a boundary-cycle command lands a period later.
    if (boundary) begin
      duty_d = (state_q == ST_RUN) ? shadow_q : '0;
    end
    if (xfer) begin
      shadow_d = conv_duty;
    end

    case (state_q)
      ST_DISARMED: begin
        if (arm) begin
          state_d   = ST_ARMING;
          shadow_d  = '0;
          arm_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (boundary) begin
          if (arm_cnt_q == ARM_W'(ARM_PERIODS - 1)) begin
            state_d  = ST_RUN;
            wd_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end else if (xfer) begin
          wd_cnt_d = '0;
        end else if (boundary) begin
          if (wd_cnt_q == WD_W'(WDOG_PERIODS - 1)) begin
            state_d = ST_FAILSAFE;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
          end
        end
      end
      ST_FAILSAFE: begin
        if (!arm) begin
          state_d = ST_DISARMED;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_DISARMED;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
      wd_cnt_q  <= '0;
      shadow_q  <= '0;
      duty_q    <= '0;
      set_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      shadow_q  <= shadow_d;
      duty_q    <= duty_d;
      set_q     <= set_d;
    end
  end

  assign mot_set  = set_q;
  assign mot_duty = duty_q;
  assign state    = state_q;
  assign fault    = (state_q == ST_FAILSAFE);

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// tb/tb_motor_pwm_sequencer.sv - self-checking bench for motor_pwm_sequencer
// Directed table and sequences plus randomized traffic against a period-level reference model.
module tb_motor_pwm_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arm;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_rpm;
  logic        mot_set;
  logic [27:0] mot_duty;
  logic [1:0]  state;
  logic        fault;

  always #5 clk = ~clk;

  motor_pwm_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .arm       (arm),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rpm   (cmd_rpm),
    .mot_set   (mot_set),
    .mot_duty  (mot_duty),
    .state     (state),
    .fault     (fault)
  );

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  // Reference model: cycles since reset, states as plain numbers 0..3.
  int m_cyc, m_state, m_arm_bnd, m_idle_bnd;
  int m_shadow[4];
  int m_duty[4];
  bit m_set;

  typedef struct {
    logic [63:0] rpm;
    logic [27:0] duty;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  function automatic int conv(int rpm);
    int d;
    if (rpm <= 500) return 0;
    d = (rpm - 500) / 64;
    return (d > 90) ? 90 : d;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_arm_bnd = 0; m_idle_bnd = 0; m_set = 0;
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 0;
      m_duty[i]   = 0;
    end
  endtask

  task automatic model_step();
    bit bnd, xfer;
    if (!resetn) begin
      model_reset();
      return;
    end
    bnd   = (m_cyc % 128) == 127;
    xfer  = cmd_valid && (m_state == 1 || m_state == 2);
    m_set = bnd;
    if (bnd) for (int i = 0; i < 4; i++) m_duty[i] = (m_state == 2) ? m_shadow[i] : 0;
    if (xfer) for (int i = 0; i < 4; i++) m_shadow[i] = conv(int'(cmd_rpm[16*i +: 16]));
    if (!arm) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1;
      m_arm_bnd = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 0;
    end else if (m_state == 1) begin
      if (bnd) m_arm_bnd++;
      if (m_arm_bnd == 16) begin
        m_state = 2;
        m_idle_bnd = 0;
      end
    end else if (m_state == 2) begin
      if (xfer) m_idle_bnd = 0;
      else if (bnd) m_idle_bnd++;
      if (m_idle_bnd == 64) m_state = 3;
    end
    m_cyc++;
  endtask

  task automatic chk_model();
    logic [27:0] ed;
    logic [63:0] exp_v, act_v;
    for (int i = 0; i < 4; i++) ed[7*i +: 7] = 7'(m_duty[i]);
    exp_v = {31'd0, m_set, ed, 2'(m_state), (m_state == 1 || m_state == 2), (m_state == 3)};
    act_v = {31'd0, mot_set, mot_duty, state, cmd_ready, fault};
    chk("model", act_v, exp_v);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    tb_cyc++;
    chk_model();
  endtask

  task automatic wait_strobe();
    for (int k = 0; k < 200; k++) begin
      tick();
      if (mot_set) return;
    end
    checks++;
    errors++;
    $display("FAIL strobe_timeout: no mot_set within 200 cycles (cycle %0d)", tb_cyc);
  endtask

  task automatic send_cmd(input logic [63:0] rpm);
    cmd_valid = 1'b1;
    cmd_rpm   = rpm;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_run();
    for (int k = 0; k < 20; k++) begin
      wait_strobe();
      if (state == 2'd2) return;
    end
    checks++;
    errors++;
    $display("FAIL run_timeout: state %0d did not reach RUN", state);
  endtask

  initial begin
    int t0;
    tbl[0] = '{rpm: {16'd65535, 16'd1140, 16'd564, 16'd500}, duty: {7'd90, 7'd10, 7'd1, 7'd0}};
    tbl[1] = '{rpm: {16'd564,   16'd563,  16'd501, 16'd0},   duty: {7'd1,  7'd0,  7'd0, 7'd0}};
    tbl[2] = '{rpm: {16'd1000,  16'd6260, 16'd6259, 16'd6580}, duty: {7'd7, 7'd90, 7'd89, 7'd90}};
    tbl[3] = '{rpm: {16'd2000,  16'd3700, 16'd0,   16'd65535}, duty: {7'd23, 7'd50, 7'd0, 7'd90}};

    resetn = 1'b0; arm = 1'b0; cmd_valid = 1'b0; cmd_rpm = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_set", mot_set, 0);
    chk("rst_duty", mot_duty, 0);
    chk("rst_state", state, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_fault", fault, 0);

    // Strobe cadence while disarmed
    resetn = 1'b1;
    t0 = tb_cyc;
    wait_strobe();
    chk("first_strobe_delay", tb_cyc - t0, 128);
    for (int k = 0; k < 3; k++) begin
      t0 = tb_cyc;
      wait_strobe();
      chk("strobe_period", tb_cyc - t0, 128);
      chk("disarmed_duty", mot_duty, 0);
      chk("disarmed_state", state, 0);
      chk("disarmed_ready", cmd_ready, 0);
    end

    // Arming: 16 boundaries at duty 0, command sent during ARMING saturates to 90
    arm = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_strobe();
      chk("arming_duty", mot_duty, 0);
      chk("arming_state", state, (k < 15) ? 1 : 2);
      if (k == 2) send_cmd({4{16'd6580}});
    end
    wait_strobe();
    chk("arm_sat_duty", mot_duty, {4{7'd90}});

    // Conversion table
    for (int e = 0; e < 4; e++) begin
      send_cmd(tbl[e].rpm);
      wait_strobe();
      wait_strobe();
      chk("conv_duty", mot_duty, tbl[e].duty);
    end

    // Boundary race: command in the boundary cycle applies one period later
    repeat (127) tick();
    cmd_valid = 1'b1;
    cmd_rpm   = {16'd500, 16'd3700, 16'd564, 16'd1140};
    tick();
    cmd_valid = 1'b0;
    chk("race_strobe", mot_set, 1);
    chk("race_old_duty", mot_duty, tbl[3].duty);
    wait_strobe();
    chk("race_new_duty", mot_duty, {7'd0, 7'd50, 7'd1, 7'd10});

    // Watchdog
    send_cmd({4{16'd2000}});
    for (int k = 1; k <= 64; k++) begin
      wait_strobe();
      if (k == 1)  chk("wd_first_duty", mot_duty, {4{7'd23}});
      if (k == 63) chk("wd_state_63", state, 2);
    end
    chk("wd_state", state, 3);
    chk("wd_fault", fault, 1);
    chk("wd_ready", cmd_ready, 0);
    wait_strobe();
    chk("wd_duty_zero", mot_duty, 0);
    arm = 1'b0;
    tick();
    chk("wd_disarm", state, 0);
    tick();
    arm = 1'b1;
    tick();
    chk("wd_rearm", state, 1);

    // Disarm mid-run
    send_cmd({4{16'd3700}});
    wait_run();
    wait_strobe();
    chk("run_duty", mot_duty, {4{7'd50}});
    repeat (30) tick();
    arm = 1'b0;
    tick();
    chk("disarm_state", state, 0);
    chk("disarm_duty_held", mot_duty, {4{7'd50}});
    wait_strobe();
    chk("disarm_duty_zero", mot_duty, 0);

    // Reset mid-period
    arm = 1'b1;
    tick();
    send_cmd({4{16'd65535}});
    wait_run();
    wait_strobe();
    chk("pre_reset_duty", mot_duty, {4{7'd90}});
    repeat (40) tick();
    resetn = 1'b0;
    tick();
    chk("midrst_outputs", {mot_set, mot_duty, state, cmd_ready, fault}, 0);
    resetn = 1'b1;

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      int rate;
      case ($urandom_range(0, 2))
        0:       rate = 0;
        1:       rate = 20;
        default: rate = 200;
      endcase
      for (int c = 0; c < 2048; c++) begin
        if ($urandom_range(0, 2999) == 0) arm = ~arm;
        resetn    = ($urandom_range(0, 3999) != 0);
        cmd_valid = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
        for (int i = 0; i < 4; i++)
          cmd_rpm[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7200));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
